// File: rtl/yi_writer.sv
// yi_writer: streams 256-bit Y result beats into memory through an AXI4
// write master. A job of Write_Length beats is split into INCR bursts of at
// most MAX_BURST beats, starting at YVAL_BASE_ADDR. Only one burst is
// outstanding at a time: the next address phase waits for the previous
// write response.
//
// Optional feature macro: YI_WRITER_BRESP_CHECK_EN
//   defined   -> a non-OKAY bresp sets the sticky Write_Error flag
//   undefined -> Write_Error is tied low and bresp is ignored
module yi_writer #(
  parameter logic [47:0] YVAL_BASE_ADDR = 48'h0000_4000_0000,
  parameter int          MAX_BURST      = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         Write_Begin,
  input  logic [31:0]  Write_Length,
  output logic         Write_Done,
  output logic         Write_Error,
  input  logic [255:0] input_data,
  input  logic         input_valid,
  output logic         input_ready,
  output logic [47:0]  m_axi_Yi_awaddr,
  output logic [7:0]   m_axi_Yi_awlen,
  output logic [2:0]   m_axi_Yi_awsize,
  output logic [1:0]   m_axi_Yi_awburst,
  output logic         m_axi_Yi_awvalid,
  input  logic         m_axi_Yi_awready,
  output logic [255:0] m_axi_Yi_wdata,
  output logic [31:0]  m_axi_Yi_wstrb,
  output logic         m_axi_Yi_wlast,
  output logic         m_axi_Yi_wvalid,
  input  logic         m_axi_Yi_wready,
  input  logic [1:0]   m_axi_Yi_bresp,
  input  logic         m_axi_Yi_bvalid,
  output logic         m_axi_Yi_bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [4:0]  MAX_BURST_S = 5'(MAX_BURST);

  state_t        state_r;
  state_t        state_next_s;
  logic [31:0]   remaining_r;
  logic [47:0]   addr_r;
  logic [4:0]    beat_r;
  logic          done_r;
  logic [4:0]    burst_s;
  logic          last_beat_s;
  logic          beat_fire_s;
  logic          b_fire_s;

  // Size of the current burst; remaining_r only changes on a write
  // response, so this is stable across the AW, W and B phases of a burst.
  always_comb begin
    if (remaining_r > MAX_BURST_W) begin
      burst_s = MAX_BURST_S;
    end else begin
      burst_s = remaining_r[4:0];
    end
  end

  assign last_beat_s = (beat_r == (burst_s - 5'd1));
  assign beat_fire_s = (state_r == W) && input_valid && m_axi_Yi_wready;
  assign b_fire_s    = (state_r == B) && m_axi_Yi_bvalid;

  // Fixed AXI attributes and the data pass-through.
  assign m_axi_Yi_awsize  = 3'b101;
  assign m_axi_Yi_awburst = 2'b01;
  assign m_axi_Yi_wstrb   = 32'hFFFF_FFFF;
  assign m_axi_Yi_wdata   = input_data;
  assign m_axi_Yi_awaddr  = addr_r;
  assign Write_Done       = done_r;

  // Next-state selection and per-state handshake outputs.
  always_comb begin
    state_next_s     = state_r;
    m_axi_Yi_awvalid = 1'b0;
    m_axi_Yi_awlen   = 8'd0;
    m_axi_Yi_wvalid  = 1'b0;
    m_axi_Yi_wlast   = 1'b0;
    m_axi_Yi_bready  = 1'b0;
    input_ready      = 1'b0;
    case (state_r)
      IDLE: begin
        if (Write_Begin) begin
          if (Write_Length == 32'd0) begin
            state_next_s = DONE;
          end else begin
            state_next_s = AW;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      AW: begin
        m_axi_Yi_awvalid = 1'b1;
        m_axi_Yi_awlen   = {3'd0, burst_s} - 8'd1;
        if (m_axi_Yi_awready) begin
          state_next_s = W;
        end else begin
          state_next_s = AW;
        end
      end
      W: begin
        m_axi_Yi_wvalid = input_valid;
        m_axi_Yi_wlast  = last_beat_s;
        input_ready     = m_axi_Yi_wready;
        if (beat_fire_s && last_beat_s) begin
          state_next_s = B;
        end else begin
          state_next_s = W;
        end
      end
      B: begin
        m_axi_Yi_bready = 1'b1;
        if (m_axi_Yi_bvalid) begin
          if (remaining_r == {27'd0, burst_s}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = AW;
          end
        end else begin
          state_next_s = B;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Job bookkeeping: remaining beats, burst address and beat-in-burst index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remaining_r <= 32'd0;
      addr_r      <= 48'd0;
      beat_r      <= 5'd0;
    end else begin
      if ((state_r == IDLE) && Write_Begin) begin
        remaining_r <= Write_Length;
        addr_r      <= YVAL_BASE_ADDR;
        beat_r      <= 5'd0;
      end else if (beat_fire_s) begin
        if (last_beat_s) begin
          beat_r <= 5'd0;
        end else begin
          beat_r <= beat_r + 5'd1;
        end
      end else if (b_fire_s) begin
        remaining_r <= remaining_r - {27'd0, burst_s};
        addr_r      <= addr_r + {38'd0, burst_s, 5'd0};
      end
    end
  end

  // Completion pulse, registered one cycle after the DONE state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == DONE);
    end
  end

`ifdef YI_WRITER_BRESP_CHECK_EN
  logic error_r;

  // Sticky error on any non-OKAY response; a newly accepted job clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      error_r <= 1'b0;
    end else if ((state_r == IDLE) && Write_Begin) begin
      error_r <= 1'b0;
    end else if (b_fire_s && (m_axi_Yi_bresp != 2'b00)) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign Write_Error = error_r;
`else
  logic unused_bresp;

  assign unused_bresp = ^m_axi_Yi_bresp;
  assign Write_Error  = 1'b0;
`endif

endmodule
